uart_boot_loader: RTL

//  Upstream of the pipelined core. Holds the core in reset, receives a program image over
//  a UART RX line and writes it byte-by-byte into the unified BRAM, then releases the core.
//  The write port drives the BRAM port-A write inputs (wea/addra/dia) while the core is held
//  in reset; the top-level mux hands port A back to fetch when cpu_rst_n rises.

---
 rtl/uart_boot_loader_if.sv | 14 +
 rtl/uart_boot_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if
//   Byte-lane write bus from the boot loader to BRAM port A.
//   mem_we   : 4-bit one-hot byte-lane write enable, single-cycle pulse per byte
//   mem_addr : word-aligned byte address (bits [1:0] always 0)
//   mem_di   : write data, the received byte replicated on all four lanes
//   master   : the loader (drives the bus); slave: the memory / port-A mux
interface uart_boot_loader_if;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;

  modport master (output mem_we, output mem_addr, output mem_di);
  modport slave  (input  mem_we, input  mem_addr, input  mem_di);
endinterface

// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Holds the core in reset, receives a program image over UART and writes it
//   byte-by-byte into BRAM port A, then releases the core.
//   Image format: 4-byte little-endian length LEN, then LEN payload bytes.
//   Optional macro BOOT_CHECKSUM_EN: one trailing byte equal to the sum of the
//   payload bytes mod 256 is required before the load is accepted.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : UART receive line (idle high, asynchronous to clk)
//   mem        : write bus to BRAM port A (master modport)
//   cpu_rst_n  : core reset, held low until a successful load
//   busy       : high from the first header start bit until DONE or ERR
//   done       : sticky, successful load
//   error      : sticky, framing / length / checksum failure
module uart_boot_loader #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int MAX_BYTES = 16384
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  uart_boot_loader_if.master   mem,
  output logic                 cpu_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] BIT_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_e;

  // ---------------- RX front end ----------------
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            start_ok;

  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    start_ok    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line half a bit later; a short low pulse is rejected.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s2_q) begin
            start_ok   = 1'b1;
            bit_d      = '0;
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};  // LSB arrives first
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin  // RX_STOP
        if (cnt_q == BIT_M1) begin
          cnt_d       = '0;
          rx_state_d  = RX_IDLE;
          rx_valid_d  = rx_s2_q;
          frame_err_d = !rx_s2_q;
        end
      end
    endcase
  end

  // ---------------- Loader FSM ----------------
  state_e       state_q, state_d;
  logic [1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [31:0]  len_q, len_d, new_len;
  logic [31:0]  idx_q, idx_d;
  logic [7:0]   sum_q, sum_d;
  logic [3:0]   we_q, we_d;
  logic [31:0]  addr_q, addr_d, di_q, di_d;
  logic         busy_q, busy_d, done_q, done_d, err_q, err_d, cpu_rst_n_q, cpu_rst_n_d;
  logic         go_done, go_err, go_tail;

  assign new_len = {shift_q, len_q[31:8]};

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    we_d        = '0;
    addr_d      = addr_q;
    di_d        = di_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    cpu_rst_n_d = cpu_rst_n_q;
    go_done     = 1'b0;
    go_err      = 1'b0;
    go_tail     = 1'b0;  // payload finished: checksum byte next, or done
    case (state_q)
      S_HDR: begin
        if (start_ok) busy_d = 1'b1;
        if (frame_err_q) go_err = 1'b1;
        else if (rx_valid_q) begin
          len_d     = new_len;
          hdr_cnt_d = hdr_cnt_q + 1'b1;
          if (hdr_cnt_q == 2'd3) begin
            if (new_len == 32'd0)                  go_tail = 1'b1;
            else if (new_len > 32'(MAX_BYTES))     go_err  = 1'b1;
            else begin
              state_d = S_DATA;
              idx_d   = '0;
              sum_d   = '0;
            end
          end
        end
      end
      S_DATA: begin
        if (frame_err_q) go_err = 1'b1;
        else begin
          if (rx_valid_q) begin
            we_d   = 4'b0001 << idx_q[1:0];
            addr_d = {idx_q[31:2], 2'b00};
            di_d   = {4{shift_q}};
            idx_d  = idx_q + 1'b1;
            sum_d  = sum_q + shift_q;
          end
          // Leave DATA during the final write pulse so DONE follows it by one clk.
          if (we_q != 4'b0000 && idx_q == len_q) go_tail = 1'b1;
        end
      end
      S_CHK: begin
        if (frame_err_q) go_err = 1'b1;
        else if (rx_valid_q) begin
          if (shift_q == sum_q) go_done = 1'b1;
          else                  go_err  = 1'b1;
        end
      end
      default: ;  // S_DONE / S_ERR hold until reset
    endcase

`ifdef BOOT_CHECKSUM_EN
    if (go_tail) state_d = S_CHK;
`else
    if (go_tail) go_done = 1'b1;
`endif
    if (go_done) begin
      state_d     = S_DONE;
      done_d      = 1'b1;
      cpu_rst_n_d = 1'b1;
      busy_d      = 1'b0;
    end
    if (go_err) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= S_HDR;
      hdr_cnt_q   <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      we_q        <= '0;
      addr_q      <= '0;
      di_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign mem.mem_we   = we_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_di   = di_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
endmodule
